// File: rtl/nic_host_driver.sv
// Host-side master for the NIC CPU port: polls status, moves one packet per tx/rx holding register.
// Optional statistics counters are built in when NIC_DRV_STATS_EN is defined.
module nic_host_driver #(
    parameter int PACKET_WIDTH = 64,
    parameter int POLL_GAP     = 0,
    parameter int STAT_WIDTH   = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    tx_valid,
    output logic                    tx_ready,
    input  logic [PACKET_WIDTH-1:0] tx_data,
    output logic                    rx_valid,
    input  logic                    rx_ready,
    output logic [PACKET_WIDTH-1:0] rx_data,
    output logic [1:0]              nic_addr,
    output logic [PACKET_WIDTH-1:0] nic_d_in,
    input  logic [PACKET_WIDTH-1:0] nic_d_out,
    output logic                    nic_en,
    output logic                    nic_en_wr,
`ifdef NIC_DRV_STATS_EN
    output logic [STAT_WIDTH-1:0]   tx_count,
    output logic [STAT_WIDTH-1:0]   rx_count,
    output logic [STAT_WIDTH-1:0]   busy_count,
`endif
    output logic [2:0]              dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_OS_RD  = 3'd1,
        S_OS_CHK = 3'd2,
        S_OB_WR  = 3'd3,
        S_IS_RD  = 3'd4,
        S_IS_CHK = 3'd5,
        S_IB_RD  = 3'd6,
        S_IB_CAP = 3'd7
    } state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic                    r_tx_full;
    logic [PACKET_WIDTH-1:0] r_tx_reg;
    logic                    r_rx_full;
    logic [PACKET_WIDTH-1:0] r_rx_data;
    logic [7:0]              r_gap;
    logic                    r_last_tx;

    // Both channels: a transfer happens on a cycle where valid and ready are both high.
    assign tx_ready  = ~r_tx_full;
    assign rx_valid  = r_rx_full;
    assign rx_data   = r_rx_data;
    assign dbg_state = r_state;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (r_gap == 8'd0) begin
                    // Round-robin when both channels want service.
                    if (r_tx_full && !r_rx_full) begin
                        w_next = r_last_tx ? S_IS_RD : S_OS_RD;
                    end else if (r_tx_full) begin
                        w_next = S_OS_RD;
                    end else if (!r_rx_full) begin
                        w_next = S_IS_RD;
                    end
                end
            end
            S_OS_RD:  w_next = S_OS_CHK;
            S_OS_CHK: w_next = nic_d_out[0] ? S_IDLE : S_OB_WR;
            S_OB_WR:  w_next = S_IDLE;
            S_IS_RD:  w_next = S_IS_CHK;
            S_IS_CHK: w_next = nic_d_out[0] ? S_IB_RD : S_IDLE;
            S_IB_RD:  w_next = S_IB_CAP;
            S_IB_CAP: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        nic_en    = 1'b0;
        nic_en_wr = 1'b0;
        nic_addr  = 2'd0;
        nic_d_in  = '0;
        case (r_state)
            S_OS_RD: begin
                nic_en   = 1'b1;
                nic_addr = 2'd3;
            end
            S_OB_WR: begin
                nic_en    = 1'b1;
                nic_en_wr = 1'b1;
                nic_addr  = 2'd2;
                nic_d_in  = r_tx_reg;
            end
            S_IS_RD: begin
                nic_en   = 1'b1;
                nic_addr = 2'd1;
            end
            S_IB_RD: begin
                nic_en   = 1'b1;
                nic_addr = 2'd0;
            end
            default: begin
                nic_en = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tx_full <= 1'b0;
            r_tx_reg  <= '0;
            r_rx_full <= 1'b0;
            r_rx_data <= '0;
            r_gap     <= 8'd0;
            r_last_tx <= 1'b0;
        end else begin
            if (tx_valid && !r_tx_full) begin
                r_tx_reg  <= tx_data;
                r_tx_full <= 1'b1;
            end
            if (r_rx_full && rx_ready) begin
                r_rx_full <= 1'b0;
            end
            case (r_state)
                S_IDLE: begin
                    if (r_gap != 8'd0) begin
                        r_gap <= r_gap - 8'd1;
                    end
                end
                S_OS_CHK: begin
                    if (nic_d_out[0]) begin
                        r_last_tx <= 1'b1;
                        r_gap     <= 8'(POLL_GAP);
                    end
                end
                S_OB_WR: begin
                    r_tx_full <= 1'b0;
                    r_last_tx <= 1'b1;
                end
                S_IS_CHK: begin
                    if (!nic_d_out[0]) begin
                        r_last_tx <= 1'b0;
                        r_gap     <= 8'(POLL_GAP);
                    end
                end
                S_IB_CAP: begin
                    r_rx_data <= nic_d_out;
                    r_rx_full <= 1'b1;
                    r_last_tx <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

`ifdef NIC_DRV_STATS_EN
    logic [STAT_WIDTH-1:0] r_tx_count;
    logic [STAT_WIDTH-1:0] r_rx_count;
    logic [STAT_WIDTH-1:0] r_busy_count;

    assign tx_count   = r_tx_count;
    assign rx_count   = r_rx_count;
    assign busy_count = r_busy_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tx_count   <= '0;
            r_rx_count   <= '0;
            r_busy_count <= '0;
        end else begin
            if (r_state == S_OB_WR) begin
                r_tx_count <= r_tx_count + 1'b1;
            end
            if (r_state == S_IB_CAP) begin
                r_rx_count <= r_rx_count + 1'b1;
            end
            if (r_state == S_OS_CHK && nic_d_out[0]) begin
                r_busy_count <= r_busy_count + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_nic_host_driver.sv
// Bench for nic_host_driver: NIC port model, host channel scoreboards, directed and random steps.
// Build with NIC_DRV_STATS_EN defined to also check the statistics counters.
module tb_nic_host_driver;

    localparam int PW  = 64;
    localparam int GAP = 2;
    localparam int SW  = 16;
    localparam byte TAG_T = 8'h54;
    localparam byte TAG_R = 8'h52;

    logic          clk = 1'b0;
    logic          reset;
    logic          tx_valid;
    logic          tx_ready;
    logic [PW-1:0] tx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic [PW-1:0] rx_data;
    logic [1:0]    nic_addr;
    logic [PW-1:0] nic_d_in;
    logic [PW-1:0] nic_d_out;
    logic          nic_en;
    logic          nic_en_wr;
    logic [2:0]    dbg_state;
`ifdef NIC_DRV_STATS_EN
    logic [SW-1:0] tx_count;
    logic [SW-1:0] rx_count;
    logic [SW-1:0] busy_count;
`endif

    nic_host_driver #(.PACKET_WIDTH(PW), .POLL_GAP(GAP), .STAT_WIDTH(SW)) dut (
        .clk(clk), .reset(reset),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data),
        .nic_addr(nic_addr), .nic_d_in(nic_d_in), .nic_d_out(nic_d_out),
        .nic_en(nic_en), .nic_en_wr(nic_en_wr),
`ifdef NIC_DRV_STATS_EN
        .tx_count(tx_count), .rx_count(rx_count), .busy_count(busy_count),
`endif
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_checks = 0;

    logic [PW-1:0] tx_exp_q[$];
    logic [PW-1:0] rx_exp_q[$];
    logic [PW-1:0] in_q[$];
    byte           served_q[$];

    int busy_left, n_writes, n_os_reads, n_ibrd, n_busy, cyc, fruit_cyc;
    bit pend_rd, os_free, is_full, fruit, prev_en, prev_rxv, prev_hs;
    logic [1:0]    pend_addr;
    logic [PW-1:0] prev_rxd;

    task automatic check(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // NIC port model plus host-side observation, evaluated mid-cycle.
    task automatic nic_step();
        cyc++;
        if (reset) begin
            pend_rd = 0; fruit = 0; prev_en = 0; prev_rxv = 0; prev_hs = 0;
            os_free = 0; is_full = 0; nic_d_out = '0;
            return;
        end
        if (pend_rd) begin
            case (pend_addr)
                2'd3: begin
                    if (busy_left > 0) begin
                        nic_d_out = 64'd1; busy_left--; n_busy++;
                        fruit = 1; fruit_cyc = cyc - 1;
                    end else begin
                        nic_d_out = 64'd0; os_free = 1;
                    end
                end
                2'd1: begin
                    if (in_q.size() > 0) begin
                        nic_d_out = 64'd1; is_full = 1;
                    end else begin
                        nic_d_out = 64'd0; fruit = 1; fruit_cyc = cyc - 1;
                    end
                end
                2'd0: begin
                    if (in_q.size() > 0) begin
                        nic_d_out = in_q.pop_front();
                        rx_exp_q.push_back(nic_d_out);
                    end
                end
                default: begin
                end
            endcase
            pend_rd = 0;
        end
        if (nic_en) begin
            check("single_outstanding", prev_en, 0);
            if (fruit) begin
                check("poll_gap", (cyc - fruit_cyc) >= (3 + GAP), 1);
                fruit = 0;
            end
            if (nic_en_wr) begin
                check("wr_addr", nic_addr, 2);
                check("wr_after_free_status", os_free, 1);
                os_free = 0;
                check("wr_expected_pending", tx_exp_q.size() > 0, 1);
                if (tx_exp_q.size() > 0) check("wr_data", nic_d_in, tx_exp_q.pop_front());
                n_writes++;
                served_q.push_back(TAG_T);
            end else begin
                check("rd_addr_legal", nic_addr == 2'd2, 0);
                if (nic_addr <= 2'd1) check("rx_rd_while_full", rx_valid, 0);
                if (nic_addr == 2'd0) begin
                    check("ib_after_status", is_full, 1);
                    is_full = 0; n_ibrd++;
                    served_q.push_back(TAG_R);
                end
                if (nic_addr == 2'd3) n_os_reads++;
                pend_rd = 1; pend_addr = nic_addr;
            end
        end
        prev_en = nic_en;
        if (prev_rxv && !prev_hs) begin
            check("rx_hold_valid", rx_valid, 1);
            check("rx_hold_data", rx_data, prev_rxd);
        end
        if (rx_valid && rx_ready) begin
            check("rx_expected_pending", rx_exp_q.size() > 0, 1);
            if (rx_exp_q.size() > 0) check("rx_data", rx_data, rx_exp_q.pop_front());
        end
        prev_rxv = rx_valid; prev_hs = rx_valid && rx_ready; prev_rxd = rx_data;
    endtask

    task automatic push_tx(input logic [PW-1:0] d);
        int t = 0;
        while (!tx_ready && t < 300) begin
            @(posedge clk); #1; t++;
        end
        check("tx_ready_wait", tx_ready, 1);
        tx_valid = 1; tx_data = d;
        tx_exp_q.push_back(d);
        @(posedge clk); #1;
        tx_valid = 0;
    endtask

    task automatic wait_writes(input int target);
        int t = 0;
        while (n_writes < target && t < 300) begin
            @(posedge clk); #1; t++;
        end
        check("write_wait", n_writes >= target, 1);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int w0, o0, t;
        int n_t;
        reset = 1; tx_valid = 0; tx_data = '0; rx_ready = 0; nic_d_out = '0;
        busy_left = 0; n_writes = 0; n_os_reads = 0; n_ibrd = 0; n_busy = 0; cyc = 0;
        fork
            forever begin
                @(negedge clk);
                nic_step();
            end
        join_none

        // Reset values
        wait_cycles(2);
        check("rst_nic_en", nic_en, 0);
        check("rst_tx_ready", tx_ready, 1);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_rx_data", rx_data, 0);
        reset = 0;

        // Single TX, output buffer free
        push_tx(64'hDEAD_BEEF_0000_0001);
        check("tx_ready_low_when_held", tx_ready, 0);
        wait_writes(1);
        check("tx_ready_after_write", tx_ready, 1);
        wait_cycles(20);
        check("tx_single_write", n_writes, 1);

        // TX backpressure: three busy polls then free
        w0 = n_writes; o0 = n_os_reads;
        busy_left = 3;
        push_tx({$urandom, $urandom});
        wait_writes(w0 + 1);
        wait_cycles(30);
        check("bp_status_reads", n_os_reads - o0, 4);
        check("bp_single_write", n_writes - w0, 1);

        // RX with host holding off
        rx_ready = 0;
        in_q.push_back(64'h0123_4567_89AB_CDEF);
        t = 0;
        while (!rx_valid && t < 100) begin
            @(posedge clk); #1; t++;
        end
        check("rx_valid_rise", rx_valid, 1);
        check("rx_data_value", rx_data, 64'h0123_4567_89AB_CDEF);
        wait_cycles(10);
        check("rx_still_valid", rx_valid, 1);
        rx_ready = 1;
        wait_cycles(1);
        rx_ready = 0;
        check("rx_cleared", rx_valid, 0);
        check("rx_queue_drained", rx_exp_q.size(), 0);

        // Both channels busy: service must alternate
        served_q.delete();
        rx_ready = 1; busy_left = 0;
        for (int i = 0; i < 4; i++) in_q.push_back({$urandom, $urandom});
        for (int i = 0; i < 4; i++) push_tx({$urandom, $urandom});
        t = 0;
        while (served_q.size() < 8 && t < 300) begin
            @(posedge clk); #1; t++;
        end
        check("alt_served_count", served_q.size(), 8);
        n_t = 0;
        foreach (served_q[i]) if (served_q[i] == TAG_T) n_t++;
        check("alt_tx_count", n_t, 4);
        for (int i = 1; i < served_q.size(); i++) check("alt_order", served_q[i] != served_q[i-1], 1);
        wait_cycles(10);

        // Random traffic
        for (int i = 0; i < 40; i++) begin
            rx_ready = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0: begin
                    busy_left = $urandom_range(0, 2);
                    push_tx({$urandom, $urandom});
                end
                1: in_q.push_back({$urandom, $urandom});
                default: wait_cycles($urandom_range(1, 8));
            endcase
        end
        rx_ready = 1;
        t = 0;
        while ((tx_exp_q.size() != 0 || in_q.size() != 0 || rx_exp_q.size() != 0
                || rx_valid || !tx_ready) && t < 3000) begin
            @(posedge clk); #1; t++;
        end
        wait_cycles(10);
        check("rnd_tx_drained", tx_exp_q.size(), 0);
        check("rnd_in_drained", in_q.size(), 0);
        check("rnd_rx_drained", rx_exp_q.size(), 0);
        check("rnd_rx_idle", rx_valid, 0);
`ifdef NIC_DRV_STATS_EN
        check("stat_tx_count", tx_count, SW'(n_writes));
        check("stat_rx_count", rx_count, SW'(n_ibrd));
        check("stat_busy_count", busy_count, SW'(n_busy));
`endif

        // Reset while checking output status with a packet held
        busy_left = 0;
        push_tx(64'hFEED_FACE_CAFE_0007);
        t = 0;
        do begin
            @(negedge clk); t++;
        end while (!(nic_en && !nic_en_wr && nic_addr == 2'd3) && t < 200);
        check("os_read_seen", nic_en && !nic_en_wr && nic_addr == 2'd3, 1);
        @(posedge clk); #1;
        reset = 1;
        wait_cycles(1);
        check("mid_rst_nic_en", nic_en, 0);
        check("mid_rst_tx_ready", tx_ready, 1);
        check("mid_rst_rx_valid", rx_valid, 0);
`ifdef NIC_DRV_STATS_EN
        check("mid_rst_tx_count", tx_count, 0);
        check("mid_rst_rx_count", rx_count, 0);
        check("mid_rst_busy_count", busy_count, 0);
`endif
        tx_exp_q.delete();
        w0 = n_writes;
        reset = 0;
        wait_cycles(30);
        check("mid_rst_no_write", n_writes - w0, 0);
        check("mid_rst_tx_ready_after", tx_ready, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
